// File: rtl/game_round_ctrl.sv
// Round sequencer for the target-shooting game: spawn, timed round, score/miss bookkeeping, game over.
// Latency: spawn_req one cycle after a start rise; hit_ack/miss_ack one cycle after the deciding edge.
// Backpressure: SPAWN waits indefinitely for i_spawn_ack; no other stall points.
//
// Ports:
//   i_clk, i_resetn          108 MHz pixel clock, async active-low reset
//   i_start                  start button (edge detected internally)
//   i_level[2:0]             difficulty, latched at game start
//   i_hit                    hit-detect level from hit_detect
//   i_spawn_ack              position generator has new coordinates
//   o_spawn_req              request a new target position (SPAWN state)
//   o_round_active           target live (ACTIVE state)
//   o_hit_ack / o_miss_ack   registered one-cycle result pulses
//   o_score[7:0]             hits this game, saturating
//   o_misses[3:0]            misses this game, saturating
//   o_time_left_ms[15:0]     remaining round time, 0 outside ACTIVE
//   o_game_end               high in GAMEOVER
module game_round_ctrl #(
  parameter int TICK_DIV        = 108000,
  parameter int BASE_TIMEOUT_MS = 2000,
  parameter int LEVEL_STEP_MS   = 250,
  parameter int MIN_TIMEOUT_MS  = 250,
  parameter int WIN_SCORE       = 15,
  parameter int MAX_MISSES      = 3
) (
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_start,
  input  logic [2:0]  i_level,
  input  logic        i_hit,
  input  logic        i_spawn_ack,
  output logic        o_spawn_req,
  output logic        o_round_active,
  output logic        o_hit_ack,
  output logic        o_miss_ack,
  output logic [7:0]  o_score,
  output logic [3:0]  o_misses,
  output logic [15:0] o_time_left_ms,
  output logic        o_game_end
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]     PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic signed [16:0] BASE_S   = 17'(BASE_TIMEOUT_MS);
  localparam logic signed [16:0] STEP_S   = 17'(LEVEL_STEP_MS);
  localparam logic signed [16:0] MIN_S    = 17'(MIN_TIMEOUT_MS);
  localparam logic [15:0]        MIN_U    = 16'(MIN_TIMEOUT_MS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SPAWN,
    S_ACTIVE,
    S_SCORE,
    S_GAMEOVER
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_start_q;
  logic [2:0]      r_level_q;
  logic [PW-1:0]   r_presc;
  logic [15:0]     r_timer;
  logic [7:0]      r_score;
  logic [3:0]      r_misses;
  logic            r_hit_ack;
  logic            r_miss_ack;

  logic            w_start_rise;
  logic            w_tick;
  logic            w_final_tick;
  logic            w_hit_evt;
  logic            w_miss_evt;
  logic            w_game_start;
  logic            w_round_load;
  logic            w_game_over;
  logic signed [16:0] w_level_s;
  logic signed [16:0] w_t_calc;
  logic [15:0]     w_t_load;

  assign w_start_rise = i_start & ~r_start_q;
  assign w_tick       = (r_state == S_ACTIVE) && (r_presc == PRESC_MAX);
  assign w_final_tick = w_tick && (r_timer == 16'd1);
  // A hit on the final tick wins: the miss is suppressed.
  assign w_hit_evt    = (r_state == S_ACTIVE) && i_hit;
  assign w_miss_evt   = w_final_tick && !i_hit;
  assign w_game_start = ((r_state == S_IDLE) || (r_state == S_GAMEOVER)) && w_start_rise;
  assign w_round_load = (r_state == S_SPAWN) && i_spawn_ack;
  assign w_game_over  = (r_score >= 8'(WIN_SCORE)) || (r_misses >= 4'(MAX_MISSES));

  // Signed so that high levels go negative and clamp to the floor instead of wrapping.
  assign w_level_s = signed'({14'd0, r_level_q});
  assign w_t_calc  = BASE_S - (w_level_s * STEP_S);
  assign w_t_load  = (w_t_calc < MIN_S) ? MIN_U : w_t_calc[15:0];

  // State register
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:     if (w_start_rise) w_state_nxt = S_SPAWN;
      S_SPAWN:    if (i_spawn_ack) w_state_nxt = S_ACTIVE;
      S_ACTIVE:   if (w_hit_evt || w_miss_evt) w_state_nxt = S_SCORE;
      S_SCORE:    w_state_nxt = w_game_over ? S_GAMEOVER : S_SPAWN;
      S_GAMEOVER: if (w_start_rise) w_state_nxt = S_SPAWN;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    o_spawn_req    = 1'b0;
    o_round_active = 1'b0;
    o_time_left_ms = 16'd0;
    o_game_end     = 1'b0;
    unique case (r_state)
      S_SPAWN:  o_spawn_req = 1'b1;
      S_ACTIVE: begin
        o_round_active = 1'b1;
        o_time_left_ms = r_timer;
      end
      S_GAMEOVER: o_game_end = 1'b1;
      default: ;
    endcase
  end

  // Datapath: start edge, level latch, round timer, counters, result pulses
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_start_q  <= 1'b0;
      r_level_q  <= 3'd0;
      r_presc    <= '0;
      r_timer    <= 16'd0;
      r_score    <= 8'd0;
      r_misses   <= 4'd0;
      r_hit_ack  <= 1'b0;
      r_miss_ack <= 1'b0;
    end else begin
      r_start_q  <= i_start;
      r_hit_ack  <= w_hit_evt;
      r_miss_ack <= w_miss_evt;

      if (w_game_start) begin
        r_score   <= 8'd0;
        r_misses  <= 4'd0;
        r_level_q <= i_level;
      end else begin
        if (w_hit_evt && (r_score != 8'hFF)) r_score <= r_score + 8'd1;
        if (w_miss_evt && (r_misses != 4'hF)) r_misses <= r_misses + 4'd1;
      end

      if (w_round_load) begin
        r_timer <= w_t_load;
        r_presc <= '0;
      end else if (r_state == S_ACTIVE) begin
        if (w_tick) begin
          r_presc <= '0;
          if (r_timer != 16'd0) r_timer <= r_timer - 16'd1;
        end else begin
          r_presc <= r_presc + 1'b1;
        end
      end
    end
  end

  assign o_hit_ack  = r_hit_ack;
  assign o_miss_ack = r_miss_ack;
  assign o_score    = r_score;
  assign o_misses   = r_misses;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl with small timing parameters.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: spawn_ack driven explicitly by the stimulus.
module tb_game_round_ctrl;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [2:0]  level;
  logic        hit;
  logic        spawn_ack;
  logic        spawn_req;
  logic        round_active;
  logic        hit_ack;
  logic        miss_ack;
  logic [7:0]  score;
  logic [3:0]  misses;
  logic [15:0] time_left_ms;
  logic        game_end;

  int n_checks = 0;
  int n_err    = 0;

  game_round_ctrl #(
    .TICK_DIV(4), .BASE_TIMEOUT_MS(20), .LEVEL_STEP_MS(4),
    .MIN_TIMEOUT_MS(4), .WIN_SCORE(3), .MAX_MISSES(2)
  ) dut (
    .i_clk(clk), .i_resetn(resetn), .i_start(start), .i_level(level),
    .i_hit(hit), .i_spawn_ack(spawn_ack), .o_spawn_req(spawn_req),
    .o_round_active(round_active), .o_hit_ack(hit_ack), .o_miss_ack(miss_ack),
    .o_score(score), .o_misses(misses), .o_time_left_ms(time_left_ms),
    .o_game_end(game_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        sr;
    logic        ra;
    logic        ha;
    logic        ma;
    logic [7:0]  sc;
    logic [3:0]  mi;
    logic [15:0] tl;
    logic        ge;
  } out_t;

  typedef struct {
    logic       start;
    logic [2:0] level;
    logic       hit;
    logic       ack;
    out_t       exp;
  } vec_t;

  vec_t vecs[14];

  function automatic out_t mk(input logic sr, input logic ra, input logic ha,
                              input logic ma, input int sc, input int mi,
                              input int tl, input logic ge);
    out_t o;
    o.sr = sr; o.ra = ra; o.ha = ha; o.ma = ma;
    o.sc = 8'(sc); o.mi = 4'(mi); o.tl = 16'(tl); o.ge = ge;
    return o;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.sr = spawn_req; o.ra = round_active; o.ha = hit_ack; o.ma = miss_ack;
    o.sc = score; o.mi = misses; o.tl = time_left_ms; o.ge = game_end;
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    start = 1'b0; level = 3'd0; hit = 1'b0; spawn_ack = 1'b0;
    repeat (2) step();
    resetn = 1'b1;
    step();
  endtask

  // From IDLE/GAMEOVER: start rise, then acknowledge the spawn request.
  task automatic begin_round(input logic [2:0] lv);
    level = lv;
    start = 1'b1; step();
    start = 1'b0; spawn_ack = 1'b1; step();
    spawn_ack = 1'b0;
  endtask

  task automatic wait_miss(output int cnt);
    cnt = 0;
    while (miss_ack !== 1'b1 && cnt < 100) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    int cnt;

    // Start, 3-cycle spawn wait, timed round at level 0, hit, ignored inputs in SPAWN.
    vecs[0]  = '{1'b0, 3'd0, 1'b0, 1'b0, mk(0,0,0,0,0,0, 0,0)};
    vecs[1]  = '{1'b1, 3'd0, 1'b0, 1'b0, mk(1,0,0,0,0,0, 0,0)};
    vecs[2]  = '{1'b0, 3'd0, 1'b0, 1'b0, mk(1,0,0,0,0,0, 0,0)};
    vecs[3]  = '{1'b0, 3'd0, 1'b0, 1'b0, mk(1,0,0,0,0,0, 0,0)};
    vecs[4]  = '{1'b0, 3'd0, 1'b0, 1'b1, mk(0,1,0,0,0,0,20,0)};
    vecs[5]  = '{1'b0, 3'd0, 1'b0, 1'b0, mk(0,1,0,0,0,0,20,0)};
    vecs[6]  = '{1'b0, 3'd0, 1'b0, 1'b0, mk(0,1,0,0,0,0,20,0)};
    vecs[7]  = '{1'b0, 3'd0, 1'b0, 1'b0, mk(0,1,0,0,0,0,20,0)};
    vecs[8]  = '{1'b0, 3'd0, 1'b0, 1'b0, mk(0,1,0,0,0,0,19,0)};
    vecs[9]  = '{1'b0, 3'd0, 1'b1, 1'b0, mk(0,0,1,0,1,0, 0,0)};
    vecs[10] = '{1'b0, 3'd0, 1'b0, 1'b0, mk(1,0,0,0,1,0, 0,0)};
    vecs[11] = '{1'b0, 3'd7, 1'b1, 1'b0, mk(1,0,0,0,1,0, 0,0)};
    vecs[12] = '{1'b1, 3'd7, 1'b0, 1'b0, mk(1,0,0,0,1,0, 0,0)};
    vecs[13] = '{1'b0, 3'd7, 1'b0, 1'b1, mk(0,1,0,0,1,0,20,0)};

    resetn = 1'b0;
    start = 1'b0; level = 3'd0; hit = 1'b0; spawn_ack = 1'b0;
    #2;
    check("reset_outputs", 64'(sample()), 64'(mk(0,0,0,0,0,0,0,0)));
    do_reset();

    for (int i = 0; i < 14; i++) begin
      start = vecs[i].start; level = vecs[i].level;
      hit = vecs[i].hit; spawn_ack = vecs[i].ack;
      step();
      check($sformatf("vec%0d", i), 64'(sample()), 64'(vecs[i].exp));
    end

    // Level 7 clamps to the 4 ms floor: miss 16 cycles after ACTIVE entry; two misses end the game.
    do_reset();
    begin_round(3'd7);
    check("lvl7_timeout", 64'(time_left_ms), 64'd4);
    wait_miss(cnt);
    check("miss1_latency", 64'(cnt), 64'd16);
    check("miss1_count", 64'(misses), 64'd1);
    check("miss1_time_left", 64'(time_left_ms), 64'd0);
    check("miss1_no_hit_ack", 64'(hit_ack), 64'd0);
    step();
    check("miss1_pulse_end", 64'(miss_ack), 64'd0);
    check("miss1_respawn", 64'(spawn_req), 64'd1);
    spawn_ack = 1'b1; step(); spawn_ack = 1'b0;
    wait_miss(cnt);
    check("miss2_latency", 64'(cnt), 64'd16);
    check("miss2_count", 64'(misses), 64'd2);
    step();
    check("miss_gameover", 64'(game_end), 64'd1);
    check("miss_gameover_spawn", 64'(spawn_req), 64'd0);

    // Three hits win; hit ignored in GAMEOVER; start restarts with a new level.
    do_reset();
    level = 3'd0;
    start = 1'b1; step(); start = 1'b0;
    for (int r = 1; r <= 3; r++) begin
      spawn_ack = 1'b1; step(); spawn_ack = 1'b0;
      hit = 1'b1; step(); hit = 1'b0;
      check($sformatf("win_hit%0d_ack", r), 64'(hit_ack), 64'd1);
      check($sformatf("win_hit%0d_score", r), 64'(score), 64'(r));
      step();
    end
    check("win_game_end", 64'(game_end), 64'd1);
    check("win_score", 64'(score), 64'd3);
    hit = 1'b1; step(); hit = 1'b0;
    check("gameover_hit_ignored", 64'(hit_ack), 64'd0);
    check("gameover_score_held", 64'(score), 64'd3);
    step();
    begin_round(3'd4);
    check("restart_score", 64'(score), 64'd0);
    check("restart_lvl4_timeout", 64'(time_left_ms), 64'd4);
    check("restart_game_end", 64'(game_end), 64'd0);

    // Hit on the same edge as the final tick: hit wins.
    do_reset();
    begin_round(3'd6);
    repeat (15) step();
    check("final_tick_time_left", 64'(time_left_ms), 64'd1);
    hit = 1'b1; step(); hit = 1'b0;
    check("tie_hit_ack", 64'(hit_ack), 64'd1);
    check("tie_no_miss_ack", 64'(miss_ack), 64'd0);
    check("tie_score", 64'(score), 64'd1);
    check("tie_misses", 64'(misses), 64'd0);
    step();
    check("tie_no_late_miss", 64'(miss_ack), 64'd0);

    // Asynchronous reset mid-round, then IDLE ignores hit.
    do_reset();
    level = 3'd0;
    start = 1'b1; step(); start = 1'b0;
    spawn_ack = 1'b1; step(); spawn_ack = 1'b0;
    hit = 1'b1; step(); hit = 1'b0;
    step();
    spawn_ack = 1'b1; step(); spawn_ack = 1'b0;
    repeat (2) step();
    check("pre_reset_active", 64'(round_active), 64'd1);
    resetn = 1'b0;
    #2;
    check("async_reset_outputs", 64'(sample()), 64'(mk(0,0,0,0,0,0,0,0)));
    step();
    resetn = 1'b1;
    hit = 1'b1;
    repeat (3) step();
    hit = 1'b0;
    check("idle_ignores_hit", 64'(sample()), 64'(mk(0,0,0,0,0,0,0,0)));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
